// File: rtl/reg_dump_tx.sv
// reg_dump_tx: sweeps the register file debug port and streams each word LSB-first as bytes.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module reg_dump_tx #(
    parameter int NB_DATA        = 32,
    parameter int N_REGISTERS    = 32,
    parameter int NB_REG_ADDRESS = 5,
    parameter int NB_BYTE        = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [NB_REG_ADDRESS-1:0] o_read_reg_address_debug,
    input  logic [NB_DATA-1:0]        i_read_reg_data_debug,
    output logic [NB_BYTE-1:0]        o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready
);
    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = $clog2(N_BYTES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        CHECKSUM,
`endif
        DONE
    } state_t;

    state_t                    state, next_state;
    logic [NB_DATA-1:0]        shift_reg;
    logic [NB_CNT-1:0]         byte_cnt;
    logic [NB_REG_ADDRESS-1:0] address;
    logic                      fire, last_byte, last_reg;

    assign fire      = o_tx_valid & i_tx_ready;
    assign last_byte = byte_cnt == NB_CNT'(N_BYTES - 1);
    assign last_reg  = address == NB_REG_ADDRESS'(N_REGISTERS - 1);
    assign o_read_reg_address_debug = address;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = i_start ? SETUP : IDLE;
            SETUP: next_state = LOAD;
            LOAD:  next_state = SEND;
`ifdef REG_DUMP_CHECKSUM_EN
            SEND:     next_state = (fire && last_byte) ? (last_reg ? CHECKSUM : SETUP) : SEND;
            CHECKSUM: next_state = fire ? DONE : CHECKSUM;
`else
            SEND:     next_state = (fire && last_byte) ? (last_reg ? DONE : SETUP) : SEND;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] checksum;

    always_ff @(posedge i_clock) begin
        if (i_reset || (state == IDLE && i_start))
            checksum <= '0;
        else if (state == SEND && fire)
            checksum <= checksum ^ shift_reg[NB_BYTE-1:0];
    end

    always_comb begin
        o_busy     = state == SETUP || state == LOAD || state == SEND || state == CHECKSUM;
        o_tx_valid = state == SEND || state == CHECKSUM;
        o_tx_data  = state == SEND ? shift_reg[NB_BYTE-1:0] : state == CHECKSUM ? checksum : '0;
        o_done     = state == DONE;
    end
`else
    always_comb begin
        o_busy     = state == SETUP || state == LOAD || state == SEND;
        o_tx_valid = state == SEND;
        o_tx_data  = state == SEND ? shift_reg[NB_BYTE-1:0] : '0;
        o_done     = state == DONE;
    end
`endif

    // Data captured in LOAD was read by the register file on the negedge inside SETUP.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
            address   <= '0;
        end else begin
            if (state == LOAD) begin
                shift_reg <= i_read_reg_data_debug;
                byte_cnt  <= '0;
            end
            if (state == SEND && fire) begin
                shift_reg <= shift_reg >> NB_BYTE;
                byte_cnt  <= byte_cnt + NB_CNT'(1);
                if (last_byte && !last_reg)
                    address <= address + NB_REG_ADDRESS'(1);
            end
            if (state == DONE)
                address <= '0;
        end
    end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: directed scoreboard bench for reg_dump_tx with a negedge register file model.
module tb_reg_dump_tx;
    logic        i_clock = 0;
    logic        i_reset = 1;
    logic        i_start = 0;
    logic        o_busy, o_done, o_tx_valid;
    logic [4:0]  addr;
    logic [31:0] rdata = '0;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 0;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  q[$];

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int DUMP_LEN = 129;
`else
    localparam int DUMP_LEN = 128;
`endif

    reg_dump_tx dut (
        .i_clock                  (i_clock),
        .i_reset                  (i_reset),
        .i_start                  (i_start),
        .o_busy                   (o_busy),
        .o_done                   (o_done),
        .o_read_reg_address_debug (addr),
        .i_read_reg_data_debug    (rdata),
        .o_tx_data                (o_tx_data),
        .o_tx_valid               (o_tx_valid),
        .i_tx_ready               (i_tx_ready)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] reg_model(input logic [4:0] a);
        return a == 0 ? 32'h0 : 32'h1111_0000 + {27'h0, a};
    endfunction

    always @(negedge i_clock) rdata <= reg_model(addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        logic [31:0] w;
        logic [7:0]  x;
        x = 8'h00;
        for (int r = 0; r < 32; r++) begin
            w = reg_model(r[4:0]);
            for (int b = 0; b < 4; b++) begin
                q.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        q.push_back(x);
`endif
    endtask

    // Runs one dump; restart_at/abort_at < 0 disable the extra i_start / mid-dump reset.
    task automatic dump(input bit bp, input bit chk_time, input int restart_at, input int abort_at);
        int         cyc, nbytes, ndone, done_cyc;
        bit         stall, restarted, ready;
        logic [7:0] prev_data, e;
        cyc = 1; nbytes = 0; ndone = 0; done_cyc = 0; stall = 0; restarted = 0; prev_data = 0;
        q.delete();
        push_expected();
        i_start = 1;
        @(posedge i_clock); #1;
        i_start = 0;
        cyc = 2;
        while (!(ndone > 0 && cyc > done_cyc + 4) && cyc < 2000) begin
            if (stall) begin
                chk("hold_data", o_tx_data, prev_data);
                chk("hold_valid", o_tx_valid, 1);
            end
            if (o_done) begin
                ndone++;
                done_cyc = cyc;
                if (chk_time) chk("done_cycle", cyc, 194);
                chk("busy_at_done", o_busy, 0);
            end
            i_start = 0;
            if (restart_at >= 0 && !restarted && nbytes == restart_at) begin
                i_start = 1;
                restarted = 1;
            end
            if (abort_at >= 0 && nbytes == abort_at && o_tx_valid) begin
                i_reset = 1;
                @(posedge i_clock); #1;
                i_reset = 0;
                chk("abort_valid", o_tx_valid, 0);
                chk("abort_busy", o_busy, 0);
                chk("abort_addr", addr, 0);
                for (int k = 0; k < 8; k++) begin
                    chk("abort_no_done", o_done, 0);
                    @(posedge i_clock); #1;
                end
                q.delete();
                return;
            end
            ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            i_tx_ready = ready;
            if (o_tx_valid && ready) begin
                e = q.size() > 0 ? q.pop_front() : 8'hxx;
                chk($sformatf("byte%0d", nbytes), o_tx_data, e);
                nbytes++;
            end
            stall = o_tx_valid && !ready;
            prev_data = o_tx_data;
            @(posedge i_clock); #1;
            cyc++;
        end
        i_start = 0;
        chk("byte_count", nbytes, DUMP_LEN);
        chk("done_count", ndone, 1);
        chk("queue_empty", q.size(), 0);
        chk("busy_after", o_busy, 0);
        chk("addr_after", addr, 0);
    endtask

    initial begin
        i_reset = 1;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 0;
        for (int k = 0; k < 5; k++) begin
            chk("rst_valid", o_tx_valid, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_addr", addr, 0);
            chk("rst_data", o_tx_data, 0);
            @(posedge i_clock); #1;
        end
        dump(0, DUMP_LEN == 128, -1, -1);
        dump(1, 0, -1, -1);
        dump(0, 0, 20, -1);
        dump(1, 0, -1, -1);
        dump(0, 0, -1, 50);
        dump(0, 0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
- Debug-side reader for the register file's debug read port.
- On a start pulse it sweeps register addresses 0..N_REGISTERS-1 through the debug address port and captures each 32-bit word.
- Each word is serialized into bytes over a valid/ready byte stream feeding the debug UART transmitter.
- Sits in the debug unit, between the datapath register file and the UART TX.

Parameters:
- NB_DATA, 32, register width; must be a multiple of NB_BYTE.
- N_REGISTERS, 32, number of registers swept.
- NB_REG_ADDRESS, 5, register address width.
- NB_BYTE, 8, width of the output byte stream.

Ports:
- i_clock  input  1  system clock; all state changes on posedge.
- i_reset  input  1  reset, synchronous, active-high.
- i_start  input  1  one-cycle request to begin a dump; ignored unless in IDLE.
- o_busy  output  1  high from the cycle after i_start is accepted until o_done.
- o_done  output  1  one-cycle pulse after the last byte is accepted.
- o_read_reg_address_debug  output  NB_REG_ADDRESS  address driven to the register file debug port.
- i_read_reg_data_debug  input  NB_DATA  debug read data; the register file updates it on negedge from the current address.
- o_tx_data  output  NB_BYTE  byte to transmit.
- o_tx_valid  output  1  o_tx_data is valid.
- i_tx_ready  input  1  sink accepts the byte on a posedge where valid and ready are both high.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_tx_valid=0, o_tx_data=0, o_read_reg_address_debug=0; FSM in IDLE; byte counter=0.
- FSM states: IDLE, SETUP, LOAD, SEND, DONE.
- IDLE:
  - If i_start=1, go to SETUP. The address is already 0.
  - Otherwise stay in IDLE.
- SETUP (1 cycle):
  - Address held stable so the register file samples it on the mid-cycle negedge.
  - Go to LOAD.
- LOAD (1 cycle):
  - At the exiting posedge, latch i_read_reg_data_debug into the NB_DATA shift register.
  - Clear the byte counter and go to SEND.
  - The latch edge is always two posedges after the address changes.
- SEND:
  - o_tx_valid=1; o_tx_data = shift register bits [NB_BYTE-1:0], so the least-significant byte goes first (little-endian).
  - On valid&ready: shift the register right by NB_BYTE and increment the byte counter.
  - After byte NB_DATA/NB_BYTE-1 is accepted:
    - if address == N_REGISTERS-1, go to DONE;
    - otherwise increment the address and go to SETUP.
  - While ready=0, o_tx_data and o_tx_valid stay stable; valid never drops without a transfer.
- DONE:
  - o_done=1 for exactly one cycle; o_tx_valid=0.
  - Address returns to 0; go to IDLE.
  - o_busy is low in DONE, so o_done and o_busy=0 coincide.
- o_busy = 1 in SETUP, LOAD and SEND.
- Byte order on the stream:
  - Registers ascend R0..R(N-1), including R0 (reads as 0).
  - Within each register, byte0 (LSB) through byte3 (MSB).
- Total bytes per dump: N_REGISTERS*NB_DATA/NB_BYTE = 128 with default parameters.
- Address wrap: the address never exceeds N_REGISTERS-1; no wrap-around beyond the last register.
- i_start while busy or in DONE is ignored; it is not queued.
- i_reset asserted mid-dump: next posedge returns all outputs to reset values and aborts the dump. No o_done is produced; any partial stream is discarded by the sink.
- Minimum dump time with ready tied high: 1 (IDLE→SETUP) + N*(1+1+4) + 1 (DONE) cycles = 194 cycles.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- When defined:
  - An NB_BYTE running XOR of all data bytes accepted in SEND is kept. It is cleared when i_start is accepted and on reset.
  - After the last register, an extra CHECKSUM state presents the XOR byte with the same valid/ready rules, then goes to DONE.
  - Dump length becomes 129 bytes.
- When not defined: no checksum register, no CHECKSUM state; SEND goes directly to DONE.

Test Plan:
- Reset, then hold: i_reset=1 for 2 cycles, then idle 5 cycles → o_tx_valid=0, o_busy=0, o_done=0, address=0 throughout.
- Full dump with ready high: model Rk = 0x11110000+k, with R0=0; pulse i_start → 128 bytes, starting 00 00 00 00 01 00 11 11 …, last byte 0x11 from R31=0x1111001F; o_done pulse exactly 194 cycles after the i_start edge; o_busy low afterwards.
- Backpressure: toggle i_tx_ready pseudo-randomly (≈50%) → identical 128-byte sequence; o_tx_data/o_tx_valid stable on every cycle with valid=1 and ready=0.
- Start while busy: pulse i_start again at byte 20 → no restart, exactly 128 bytes, single o_done; a new i_start after o_done starts a second dump from R0.
- Reset mid-dump: assert i_reset during byte 50 → next cycle valid=0, busy=0, address=0, no o_done; a subsequent i_start produces a complete 128-byte dump.
- With REG_DUMP_CHECKSUM_EN: same register data as the full-dump test → 129th byte equals the XOR of the 128 data bytes (bench-computed); o_done follows acceptance of the 129th byte.
